// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with ID-stage redirect, speculative history recovery
// and saturating prediction/mispredict statistics.
module gshare_branch_predictor #(
  parameter int XLEN      = 32,
  parameter int GHR_BITS  = 4,
  parameter int CTR_BITS  = 2,
  parameter int CTR_INIT  = 1,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_early,
  input  logic                 branch_early,
  input  logic                 stall_id,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      immID,
  input  logic                 branch_resolved,
  input  logic                 actual_taken,
  input  logic                 mispredict,
  input  logic [GHR_BITS-1:0]  pht_indexMEM,
  input  logic [GHR_BITS-1:0]  ghrMEM,
  output logic [XLEN-1:0]      PC_Jump,
  output logic [1:0]           flush,
  output logic                 jump_taken,
  output logic                 pred_taken,
  output logic [GHR_BITS-1:0]  pht_index,
  output logic [GHR_BITS-1:0]  ghr_snapshot,
  output logic [XLEN-1:0]      PC_saved,
  output logic [STAT_BITS-1:0] pred_count,
  output logic [STAT_BITS-1:0] mispred_count
);

  localparam int PHT_SIZE = 1 << GHR_BITS;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] ctr,
                                                   input logic up);
    logic [CTR_BITS-1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != {CTR_BITS{1'b1}}) nxt = ctr + CTR_BITS'(1);
      else                         nxt = ctr;
    end else begin
      if (ctr != {CTR_BITS{1'b0}}) nxt = ctr - CTR_BITS'(1);
      else                         nxt = ctr;
    end
    return nxt;
  endfunction

  function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] cnt,
                                                    input logic en);
    logic [STAT_BITS-1:0] nxt;
    nxt = cnt;
    if (en && (cnt != {STAT_BITS{1'b1}})) nxt = cnt + STAT_BITS'(1);
    else                                  nxt = cnt;
    return nxt;
  endfunction

  logic [CTR_BITS-1:0]  pht_q [PHT_SIZE];
  logic [CTR_BITS-1:0]  pht_d [PHT_SIZE];
  logic [GHR_BITS-1:0]  ghr_spec_q, ghr_spec_d;
  logic [GHR_BITS-1:0]  ghr_commit_q, ghr_commit_d;
  logic [STAT_BITS-1:0] pred_count_q, pred_count_d;
  logic [STAT_BITS-1:0] mispred_count_q, mispred_count_d;

  logic [GHR_BITS-1:0]  pht_index_s;
  logic [CTR_BITS-1:0]  upd_ctr_s;
  logic [CTR_BITS-1:0]  ctr_s;
  logic                 mispred_s;
  logic                 accept_s;

  // Prediction path: index, same-entry bypass of the resolving update, redirect outputs
  always_comb begin
    pht_index_s = pc[GHR_BITS+1:2] ^ ghr_spec_q;
    upd_ctr_s   = ctr_step(pht_q[pht_indexMEM], actual_taken);
    mispred_s   = branch_resolved & mispredict;
    accept_s    = branch_early & ~stall_id;
    if (branch_resolved && (pht_indexMEM == pht_index_s)) ctr_s = upd_ctr_s;
    else                                                  ctr_s = pht_q[pht_index_s];

    pred_taken    = branch_early & ctr_s[CTR_BITS-1];
    jump_taken    = (jump_early | pred_taken) & ~mispred_s;
    PC_Jump       = jump_taken ? immID : {XLEN{1'b0}};
    if (mispred_s)       flush = 2'b10;
    else if (jump_taken) flush = 2'b01;
    else                 flush = 2'b00;
    pht_index     = pht_index_s;
    ghr_snapshot  = ghr_spec_q;
    PC_saved      = pc;
    pred_count    = pred_count_q;
    mispred_count = mispred_count_q;
  end

  // Next state: PHT training, history (recovery beats the ID shift), statistics
  always_comb begin
    pht_d = pht_q;
    if (branch_resolved) pht_d[pht_indexMEM] = upd_ctr_s;
    else                 pht_d = pht_q;

    if (mispred_s)     ghr_spec_d = {ghrMEM[GHR_BITS-2:0], actual_taken};
    else if (accept_s) ghr_spec_d = {ghr_spec_q[GHR_BITS-2:0], pred_taken};
    else               ghr_spec_d = ghr_spec_q;

    if (branch_resolved) ghr_commit_d = {ghr_commit_q[GHR_BITS-2:0], actual_taken};
    else                 ghr_commit_d = ghr_commit_q;

    pred_count_d    = stat_inc(pred_count_q, accept_s);
    mispred_count_d = stat_inc(mispred_count_q, mispred_s);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= CTR_BITS'(CTR_INIT);
      ghr_spec_q      <= {GHR_BITS{1'b0}};
      ghr_commit_q    <= {GHR_BITS{1'b0}};
      pred_count_q    <= {STAT_BITS{1'b0}};
      mispred_count_q <= {STAT_BITS{1'b0}};
    end else begin
      pht_q           <= pht_d;
      ghr_spec_q      <= ghr_spec_d;
      ghr_commit_q    <= ghr_commit_d;
      pred_count_q    <= pred_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: a table-level model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_gshare_branch_predictor;
  localparam int XLEN = 32, GB = 4, CB = 2, CI = 1, SB = 4;
  localparam int NENT = 16, CMAX = 3, SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic je, be, stall, br_res, at, misp;
  logic [XLEN-1:0] pc, imm;
  logic [GB-1:0] idx_mem, ghr_mem;
  logic [XLEN-1:0] pc_jump, pc_saved;
  logic [1:0] flush;
  logic jt, pt;
  logic [GB-1:0] pidx, gsnap;
  logic [SB-1:0] pcnt, mcnt;

  int checks = 0, fails = 0;

  gshare_branch_predictor #(.XLEN(XLEN), .GHR_BITS(GB), .CTR_BITS(CB), .CTR_INIT(CI),
                            .STAT_BITS(SB)) dut (
    .clk(clk), .rst(rst), .jump_early(je), .branch_early(be), .stall_id(stall),
    .pc(pc), .immID(imm), .branch_resolved(br_res), .actual_taken(at),
    .mispredict(misp), .pht_indexMEM(idx_mem), .ghrMEM(ghr_mem),
    .PC_Jump(pc_jump), .flush(flush), .jump_taken(jt), .pred_taken(pt),
    .pht_index(pidx), .ghr_snapshot(gsnap), .PC_saved(pc_saved),
    .pred_count(pcnt), .mispred_count(mcnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as plain integers, history as an integer shift register
  int m_pht[NENT];
  int m_ghr, m_pcnt, m_mcnt;

  function automatic int sat(input int v, input bit up);
    if (up) return (v >= CMAX) ? CMAX : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic int m_index();
    return ((pc >> 2) ^ m_ghr) % NENT;
  endfunction

  function automatic bit m_pred();
    int c;
    c = m_pht[m_index()];
    if (br_res && int'(idx_mem) == m_index()) c = sat(m_pht[idx_mem], at);
    return be && (c >= (CMAX + 1) / 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit p;
    if (rst) begin
      foreach (m_pht[i]) m_pht[i] = CI;
      m_ghr = 0; m_pcnt = 0; m_mcnt = 0;
    end else begin
      p = m_pred();
      if (be && !stall && m_pcnt < SMAX) m_pcnt++;
      if (br_res && misp && m_mcnt < SMAX) m_mcnt++;
      if (br_res && misp)   m_ghr = ((int'(ghr_mem) * 2) + int'(at)) % NENT;
      else if (be && !stall) m_ghr = ((m_ghr * 2) + int'(p)) % NENT;
      if (br_res) m_pht[idx_mem] = sat(m_pht[idx_mem], at);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit p, m, j;
    if (rst) begin
      chk("rst_ghr", gsnap, 0);
      chk("rst_pcnt", pcnt, 0);
      chk("rst_mcnt", mcnt, 0);
    end else begin
      p = m_pred();
      m = br_res && misp;
      j = (je || p) && !m;
      chk("pht_index", pidx, m_index());
      chk("ghr_snapshot", gsnap, m_ghr);
      chk("pred_taken", pt, p);
      chk("jump_taken", jt, j);
      chk("PC_Jump", pc_jump, j ? imm : 0);
      chk("flush", flush, m ? 2 : (j ? 1 : 0));
      chk("PC_saved", pc_saved, pc);
      chk("pred_count", pcnt, m_pcnt);
      chk("mispred_count", mcnt, m_mcnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; je = 0; be = 0; stall = 0; br_res = 0; at = 0; misp = 0;
    pc = '0; imm = '0; idx_mem = '0; ghr_mem = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // First prediction after reset: weakly not-taken at index 4
    be = 1; pc = 32'h10; imm = 32'h40;
    @(negedge clk);
    chk("t1_index", pidx, 4); chk("t1_pred", pt, 0);
    chk("t1_flush", flush, 0); chk("t1_pcj", pc_jump, 0);
    cyc();
    chk("t1_ghr", gsnap, 4'b0000); chk("t1_pcnt", pcnt, 1);

    // Train entry 4 taken three times (1->2->3->3), then predict it
    be = 0; br_res = 1; at = 1; idx_mem = 4;
    cyc(); cyc(); cyc();
    br_res = 0; be = 1; pc = 32'h10;
    @(negedge clk);
    chk("t2_pred", pt, 1); chk("t2_jt", jt, 1);
    chk("t2_pcj", pc_jump, 32'h40); chk("t2_flush", flush, 1);
    cyc();
    chk("t2_ghr", gsnap, 4'b0001);

    // Bypass: entry 5 is 1, resolving taken in the same cycle it is predicted
    br_res = 1; at = 1; idx_mem = 5;
    @(negedge clk);
    chk("t3_index", pidx, 5); chk("t3_pred", pt, 1);
    cyc();
    br_res = 0; be = 0;

    // Load ghr_spec = 1011 through a recovery, then recover to 0101 against an ID branch+jump
    br_res = 1; misp = 1; at = 1; idx_mem = 0; ghr_mem = 4'b0101;
    cyc();
    chk("t4_ghr_pre", gsnap, 4'b1011);
    ghr_mem = 4'b0010; be = 1; je = 1;
    @(negedge clk);
    chk("t4_flush", flush, 2); chk("t4_jt", jt, 0); chk("t4_pcj", pc_jump, 0);
    cyc();
    chk("t4_ghr", gsnap, 4'b0101); chk("t4_mcnt", mcnt, 2);
    br_res = 0; misp = 0; je = 0;

    // Stall for three cycles: history and count move once, on release
    stall = 1;
    cyc(); cyc(); cyc();
    chk("t5_ghr_held", gsnap, 4'b0101); chk("t5_pcnt_held", pcnt, 4);
    stall = 0;
    cyc();
    chk("t5_ghr", gsnap, 4'b1010); chk("t5_pcnt", pcnt, 5);
    be = 0;

    // Mispredict without branch_resolved is ignored
    misp = 1;
    @(negedge clk);
    chk("t6_flush", flush, 0);
    cyc();
    chk("t6_mcnt", mcnt, 2);
    misp = 0;

    // Unconditional jump
    je = 1; imm = 32'h1234;
    @(negedge clk);
    chk("t7_jt", jt, 1); chk("t7_pcj", pc_jump, 32'h1234); chk("t7_flush", flush, 1);
    cyc();
    je = 0;

    // Twenty accepted predictions saturate the 4-bit count
    for (int i = 0; i < 20; i++) begin
      be = 1; pc = 32'(i * 4);
      cyc();
    end
    chk("t8_pcnt_sat", pcnt, 15);

    // Mixed training while predicting
    for (int i = 0; i < 16; i++) begin
      br_res = 1; at = i[0] ^ i[2]; idx_mem = 4'(i); be = 1; pc = 32'(i * 8);
      misp = (i % 5 == 0); ghr_mem = 4'(i * 3);
      cyc();
    end
    br_res = 0; misp = 0; be = 0;

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t9_ghr", gsnap, 0); chk("t9_pcnt", pcnt, 0); chk("t9_mcnt", mcnt, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    be = 1; pc = 32'h10; imm = 32'h40;
    @(negedge clk);
    chk("t9_index", pidx, 4); chk("t9_pred", pt, 0);
    cyc();
    be = 0;
    cyc();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Parametrised gshare direction predictor and ID-stage redirect unit.
- Generalises the fixed 3-bit-history / 2-bit-counter predictor:
  - configurable history length and counter width;
  - speculative global history with mispredict recovery from a pipelined snapshot;
  - same-index update-to-predict bypass;
  - saturating prediction and mispredict statistics counters.
- Sits between ID, which supplies the early jump/branch decode and target, and MEM, which supplies resolution.

Parameters:
- XLEN, 32, PC/target width.
- GHR_BITS, 4, history length and PHT index width; PHT has 2^GHR_BITS entries; legal range 2..10.
- CTR_BITS, 2, saturating counter width; legal range 1..4.
- CTR_INIT, 1, counter reset value; must be < 2^CTR_BITS.
- STAT_BITS, 16, width of statistics counters.

Ports:
Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- jump_early  in  1  ID holds an unconditional JAL.
- branch_early  in  1  ID holds a conditional branch.
- stall_id  in  1  ID stage held this cycle.
- pc  in  XLEN  PC of the ID instruction.
- immID  in  XLEN  precomputed branch/jump target.
- branch_resolved  in  1  MEM resolves a branch this cycle.
- actual_taken  in  1  resolved direction.
- mispredict  in  1  resolved direction differed from prediction; valid only with branch_resolved.
- pht_indexMEM  in  GHR_BITS  index used at prediction time, carried down the pipe.
- ghrMEM  in  GHR_BITS  speculative GHR snapshot taken at prediction time, carried down the pipe.
- PC_Jump  out  XLEN  redirect target; immID when jump_taken, else 0.
- flush  out  2  00 none; 01 flush IF (predicted redirect); 10 mispredict (IF+ID).
- jump_taken  out  1  ID redirect request.
- pred_taken  out  1  direction prediction for the ID branch.
- pht_index  out  GHR_BITS  index to carry with the branch.
- ghr_snapshot  out  GHR_BITS  current speculative GHR, to carry with the branch.
- PC_saved  out  XLEN  equals pc (fall-through recovery base).
- pred_count  out  STAT_BITS  accepted conditional predictions.
- mispred_count  out  STAT_BITS  mispredicts.

Behaviour:
- Reset (async, immediate):
  - ghr_spec = 0, ghr_commit = 0;
  - every PHT entry = CTR_INIT;
  - pred_count = mispred_count = 0;
  - combinational outputs follow their reset-state inputs (with branch_early = jump_early = 0: PC_Jump = 0, flush = 00, jump_taken = 0).
  - Reset mid-flight discards all history; no partial update completes.
- Indexing: pht_index = pc[GHR_BITS+1:2] XOR ghr_spec. ghr_snapshot = ghr_spec.
- Counter read (ctr) and bypass:
  - If branch_resolved and pht_indexMEM == pht_index, ctr is the post-update value of that entry.
  - Otherwise ctr is the stored value.
- Prediction: pred_taken = branch_early AND ctr MSB. Latency 0; fully combinational from pc/ghr_spec.
- Redirect:
  - jump_taken = (jump_early OR pred_taken) AND NOT (branch_resolved AND mispredict).
  - PC_Jump = jump_taken ? immID : 0.
  - flush:
    - 10 if branch_resolved AND mispredict (priority);
    - else 01 if jump_taken;
    - else 00.
- PHT update, on branch_resolved:
  - entry[pht_indexMEM] increments if actual_taken, else decrements;
  - saturates at 2^CTR_BITS-1 and 0.
- Speculative GHR, priority order each edge:
  - branch_resolved AND mispredict: ghr_spec <= {ghrMEM[GHR_BITS-2:0], actual_taken}. This overrides any same-cycle ID update.
  - Else branch_early AND NOT stall_id: ghr_spec <= {ghr_spec[GHR_BITS-2:0], pred_taken}.
  - Else hold. A stalled branch shifts exactly once, on the cycle stall_id drops.
- Commit GHR: on branch_resolved, ghr_commit <= {ghr_commit[GHR_BITS-2:0], actual_taken}. Debug only; not a port.
- Statistics:
  - pred_count increments on branch_early AND NOT stall_id;
  - mispred_count increments on branch_resolved AND mispredict;
  - both saturate at all-ones; no wrap.
- Illegal input: mispredict without branch_resolved is ignored.

Test Plan:
- After reset (GHR_BITS=4, CTR_INIT=1), branch_early=1, pc=0x00000010, immID=0x40 → pht_index=4, pred_taken=0, flush=00, PC_Jump=0; next edge ghr_spec=0000.
- Resolve twice taken at pht_indexMEM=4, no mispredict → entry 4 goes 1→2→3, then saturates at 3 on a third taken; a later predict at index 4 → jump_taken=1, PC_Jump=immID, flush=01.
- Same-cycle bypass: entry 5 = 1, branch_resolved with actual_taken=1 and pht_indexMEM=5 while ID predicts at index 5 → pred_taken=1 in that cycle.
- Mispredict recovery: ghr_spec=1011, ghrMEM=0010, actual_taken=1, mispredict=1, concurrent branch_early=1 → ghr_spec=0101 next edge, flush=10, jump_taken=0, mispred_count+1.
- stall_id held 3 cycles with branch_early=1 → ghr_spec and pred_count change exactly once, after release.
- Statistics saturation: STAT_BITS=4, 20 accepted predictions → pred_count=15. Assert rst mid-run → all state returns to reset values asynchronously.
